pulse_train_generator: RTL and testbench
========================================

PULSE_TRAIN_GENERATOR -- requirements
Module: pulse_train_generator

Interface
REQ-001 SHALL have parameter N, default 8: width of the period, width and count fields.
REQ-002 SHALL have parameter CHANNELS, default 4: number of independent pulse channels.
REQ-003 SHALL have port clk, input, 1, clock; reset rst, synchronous, active-high.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port ena, input, 1, global enable.
REQ-006 SHALL have port start, input, CHANNELS, per-channel start request.
REQ-007 SHALL have port stop, input, CHANNELS, per-channel stop request.
REQ-008 SHALL have ports cfg_valid (in, 1), cfg_ready (out, 1) and cfg_chan (in, CW = max(1, clog2(CHANNELS))): config handshake and target channel.
REQ-009 SHALL have ports cfg_period (in, N), cfg_width (in, N), cfg_count (in, N) and cfg_mode (in, 2): config payload.
REQ-010 SHALL have port out, output, CHANNELS, pulse outputs (registered).
REQ-011 SHALL have port done, output, CHANNELS, one-cycle completion strobe (registered).

Function
REQ-012 Each channel SHALL hold active config (period P, width W, count C, mode) plus one shadow slot with a pending flag.
REQ-013 A config transfer SHALL occur on the edge where cfg_valid & cfg_ready; cfg_ready = !pending[cfg_chan]; cfg_chan >= CHANNELS SHALL give cfg_ready=1 and discard the payload.
REQ-014 Shadow SHALL copy to active immediately if the channel is IDLE, otherwise at the period wrap (counter == P_eff-1), clearing pending; a wrap-time update SHALL never alter the current period.
REQ-015 P_eff = max(P,1); the counter SHALL run 0..P_eff-1 then wrap to 0.
REQ-016 In RUN, out SHALL be high while counter < W (W=0: always low; W >= P_eff: always high).
REQ-017 Channel FSM SHALL be IDLE -> RUN on start (counter=0, burst=0); start while RUN SHALL be ignored.
REQ-018 Mode 0 CONTINUOUS: SHALL stay RUN until stop.
REQ-019 Mode 1 ONESHOT: SHALL return to IDLE after one period and pulse done for one cycle.
REQ-020 Mode 2 BURST: SHALL run max(C,1) periods, then IDLE with one-cycle done; mode 3 SHALL behave as ONESHOT.
REQ-021 Latency: start sampled at edge t SHALL give counter=0 and out per REQ-016 from cycle t+1; done SHALL assert in the first IDLE cycle.
REQ-022 stop SHALL force IDLE and out=0 on the next edge without done; stop and start together SHALL resolve as stop.
REQ-023 An IDLE-channel config transfer together with start on the same edge SHALL run with the new config.
REQ-024 ena=0 SHALL freeze counters, FSM and burst count and force out=0 and done=0; config transfers SHALL still complete.
REQ-025 Channels SHALL be fully independent; no channel's state SHALL affect another's timing.

Reset
REQ-026 rst SHALL clear every channel to IDLE, counters 0, all active/shadow config 0, pending 0, out 0 and done 0, and SHALL override ena, start and cfg traffic.
REQ-027 rst mid-burst SHALL abort without done.

Configuration
REQ-028 Macro PULSE_TRAIN_BURST_EN: when defined, BURST mode and cfg_count storage SHALL be compiled in.
REQ-029 Without PULSE_TRAIN_BURST_EN, mode 2 SHALL behave as ONESHOT, cfg_count SHALL be ignored and no burst counter SHALL exist; ports SHALL be unchanged.

Structure
REQ-030 Package pulse_train_pkg SHALL hold the mode enum (CONTINUOUS, ONESHOT, BURST, RSVD), the channel state enum (IDLE, RUN) and the config struct typedef.
REQ-031 SHALL instantiate sub-module pulse_channel CHANNELS times via generate; the top SHALL hold only config decode and the handshake.

Verification
REQ-032 Continuous: ch0 P=5, W=2, start at t -> out0 = 1,1,0,0,0 repeating from t+1; done0 never asserted.
REQ-033 Oneshot: ch1 P=4, W=1 -> out1 high in t+1 only, done1 high in t+5, then IDLE.
REQ-034 Burst (macro on): ch2 P=3, W=1, C=3 -> three pulses at t+1, t+4, t+7, done2 at t+10; macro off -> single pulse, done2 at t+4.
REQ-035 Live update: ch0 running P=5 W=2, write P=2 W=1 mid-period -> the current period completes unchanged, then 1,0 pattern; a second write before the wrap sees cfg_ready=0.
REQ-036 Edges: W=0 -> out always 0; W=7 with P=4 -> out constantly 1; P=0 -> 1-cycle period; stop+start same edge -> IDLE.
REQ-037 ena low for 3 cycles mid-period -> out=0 and counter frozen, then resumes at the same count; rst during a burst -> all outputs 0 next cycle, no done.

Source files
------------

// File: rtl/pulse_train_pkg.sv
// rtl/pulse_train_pkg.sv - shared mode/state enums and config record for the pulse train generator
package pulse_train_pkg;

  // Config fields are carried at a fixed width; N-bit payloads are zero-extended into them.
  localparam int unsigned PT_FIELD_W = 32;

  typedef enum logic [1:0] {
    CONTINUOUS = 2'd0,
    ONESHOT    = 2'd1,
    BURST      = 2'd2,
    RSVD       = 2'd3
  } pt_mode_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } pt_state_e;

  typedef struct packed {
    pt_mode_e                mode;
    logic [PT_FIELD_W-1:0]   period;
    logic [PT_FIELD_W-1:0]   width;
    logic [PT_FIELD_W-1:0]   count;
  } pt_cfg_t;

  // Period and burst length of zero both behave as one.
  function automatic logic [PT_FIELD_W-1:0] pt_at_least_one(input logic [PT_FIELD_W-1:0] v);
    return (v == '0) ? PT_FIELD_W'(1) : v;
  endfunction

endpackage

// File: rtl/pulse_channel.sv
// rtl/pulse_channel.sv - one pulse channel: active/shadow config, period counter and IDLE/RUN FSM; PULSE_TRAIN_BURST_EN adds the burst counter
module pulse_channel
  import pulse_train_pkg::*;
#(
  parameter int N = 8
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    ena,
  input  logic    start,
  input  logic    stop,
  input  logic    cfg_wr,
  input  pt_cfg_t cfg_i,
  output logic    pending_o,
  output logic    out_o,
  output logic    done_o
);

  localparam int unsigned FW = PT_FIELD_W;

  pt_state_e     state_q, state_d;
  logic [N-1:0]  cnt_q, cnt_d;
  pt_cfg_t       active_q, active_d;
  pt_cfg_t       shadow_q, shadow_d;
  logic          pending_q, pending_d;
  logic          out_q, out_d;
  logic          done_q, done_d;
`ifdef PULSE_TRAIN_BURST_EN
  logic [N-1:0]  burst_q, burst_d;
`else
  logic          count_unused;
  assign count_unused = ^{active_q.count, shadow_q.count};
`endif

  logic [FW-1:0] cnt_ext;
  logic [FW-1:0] cnt_ext_d;
  logic [FW-1:0] last_idx;
  logic          wrap;
  logic          finish;

  // Next-state: config staging, counter advance, period-end decisions and registered outputs.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    active_d  = active_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;
    done_d    = 1'b0;
    finish    = 1'b0;
`ifdef PULSE_TRAIN_BURST_EN
    burst_d   = burst_q;
`endif
    cnt_ext   = FW'(cnt_q);
    last_idx  = pt_at_least_one(active_q.period) - FW'(1);
    wrap      = (cnt_ext == last_idx);

    if (state_q == IDLE) begin
      // Idle channels take new config at once, so a same-edge start uses it.
      if (cfg_wr) begin
        active_d = cfg_i;
      end else if (pending_q) begin
        active_d = shadow_q;
      end
      pending_d = 1'b0;
      if (ena && start && !stop) begin
        state_d = RUN;
        cnt_d   = '0;
`ifdef PULSE_TRAIN_BURST_EN
        burst_d = '0;
`endif
      end
    end else if (ena && stop) begin
      state_d = IDLE;
      cnt_d   = '0;
      if (cfg_wr) begin
        shadow_d  = cfg_i;
        pending_d = 1'b1;
      end
    end else if (ena && wrap) begin
      // Period boundary: staged config becomes active for the next period only.
      cnt_d = '0;
      if (cfg_wr) begin
        active_d = cfg_i;
      end else if (pending_q) begin
        active_d = shadow_q;
      end
      pending_d = 1'b0;
      // Run length is judged by the config of the period that just ended.
      case (active_q.mode)
        CONTINUOUS: finish = 1'b0;
`ifdef PULSE_TRAIN_BURST_EN
        BURST:      finish = (FW'(burst_q) + FW'(1)) >= pt_at_least_one(active_q.count);
`endif
        default:    finish = 1'b1;
      endcase
      if (finish) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
`ifdef PULSE_TRAIN_BURST_EN
      else if (burst_q != '1) begin
        burst_d = burst_q + N'(1);
      end
`endif
    end else begin
      if (ena) begin
        cnt_d = cnt_q + N'(1);
      end
      if (cfg_wr) begin
        shadow_d  = cfg_i;
        pending_d = 1'b1;
      end
    end

    cnt_ext_d = FW'(cnt_d);
    out_d     = ena && (state_d == RUN) && (cnt_ext_d < active_d.width);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      active_q  <= '0;
      shadow_q  <= '0;
      pending_q <= 1'b0;
      out_q     <= 1'b0;
      done_q    <= 1'b0;
`ifdef PULSE_TRAIN_BURST_EN
      burst_q   <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      active_q  <= active_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      out_q     <= out_d;
      done_q    <= done_d;
`ifdef PULSE_TRAIN_BURST_EN
      burst_q   <= burst_d;
`endif
    end
  end

  assign pending_o = pending_q;
  assign out_o     = out_q;
  assign done_o    = done_q;

endmodule

// File: rtl/pulse_train_generator.sv
// rtl/pulse_train_generator.sv - config decode and handshake over CHANNELS pulse_channel instances; PULSE_TRAIN_BURST_EN enables burst mode
module pulse_train_generator
  import pulse_train_pkg::*;
#(
  parameter  int N        = 8,
  parameter  int CHANNELS = 4,
  localparam int CW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ena,
  input  logic [CHANNELS-1:0] start,
  input  logic [CHANNELS-1:0] stop,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CW-1:0]       cfg_chan,
  input  logic [N-1:0]        cfg_period,
  input  logic [N-1:0]        cfg_width,
  input  logic [N-1:0]        cfg_count,
  input  logic [1:0]          cfg_mode,
  output logic [CHANNELS-1:0] out,
  output logic [CHANNELS-1:0] done
);

  logic [CHANNELS-1:0]  pending;
  logic [(1<<CW)-1:0]   pending_pad;
  logic                 cfg_fire;
  pt_cfg_t              cfg_word;

`ifndef PULSE_TRAIN_BURST_EN
  logic cfg_count_unused;
  assign cfg_count_unused = ^cfg_count;
`endif

  // Handshake: unused channel numbers see a zero pending bit, so they accept and drop the payload.
  always_comb begin
    pending_pad                 = '0;
    pending_pad[CHANNELS-1:0]   = pending;
    cfg_ready                   = !pending_pad[cfg_chan];
    cfg_fire                    = cfg_valid && cfg_ready;
    cfg_word                    = '0;
    cfg_word.mode               = pt_mode_e'(cfg_mode);
    cfg_word.period             = PT_FIELD_W'(cfg_period);
    cfg_word.width              = PT_FIELD_W'(cfg_width);
`ifdef PULSE_TRAIN_BURST_EN
    cfg_word.count              = PT_FIELD_W'(cfg_count);
`endif
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    pulse_channel #(
      .N(N)
    ) u_chan (
      .clk       (clk),
      .rst       (rst),
      .ena       (ena),
      .start     (start[i]),
      .stop      (stop[i]),
      .cfg_wr    (cfg_fire && (cfg_chan == CW'(i))),
      .cfg_i     (cfg_word),
      .pending_o (pending[i]),
      .out_o     (out[i]),
      .done_o    (done[i])
    );
  end

endmodule

// File: tb/tb_pulse_train_generator.sv
// tb/tb_pulse_train_generator.sv - scoreboard bench with a behavioural channel model and directed plus random stimulus
`timescale 1ns/1ps
module tb_pulse_train_generator;

  localparam int N  = 8;
  localparam int CH = 3;
  localparam int CW = 2;
`ifdef PULSE_TRAIN_BURST_EN
  localparam bit BURST_ON = 1'b1;
`else
  localparam bit BURST_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          ena;
  logic [CH-1:0] start;
  logic [CH-1:0] stop;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [CW-1:0] cfg_chan;
  logic [N-1:0]  cfg_period;
  logic [N-1:0]  cfg_width;
  logic [N-1:0]  cfg_count;
  logic [1:0]    cfg_mode;
  logic [CH-1:0] out;
  logic [CH-1:0] done;

  always #5 clk = ~clk;

  pulse_train_generator #(.N(N), .CHANNELS(CH)) dut (
    .clk        (clk),
    .rst        (rst),
    .ena        (ena),
    .start      (start),
    .stop       (stop),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_chan   (cfg_chan),
    .cfg_period (cfg_period),
    .cfg_width  (cfg_width),
    .cfg_count  (cfg_count),
    .cfg_mode   (cfg_mode),
    .out        (out),
    .done       (done)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  logic [2*CH-1:0] exp_q[$];

  // Reference model: each channel is "running or not", a phase within the period,
  // periods completed since start, and the active/staged settings as plain integers.
  bit m_run[CH];
  int m_ph[CH];
  int m_np[CH];
  int a_p[CH], a_w[CH], a_c[CH], a_m[CH];
  int s_p[CH], s_w[CH], s_c[CH], s_m[CH];
  bit m_pend[CH];
  bit e_out[CH];
  bit e_done[CH];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, got, exp);
    end
  endtask

  task automatic model_step();
    int  sel;
    bit  fire;
    bit  wr;
    int  old_m, old_c, limit, peff;
    if (rst) begin
      for (int c = 0; c < CH; c++) begin
        m_run[c] = 0; m_ph[c] = 0; m_np[c] = 0; m_pend[c] = 0;
        a_p[c] = 0; a_w[c] = 0; a_c[c] = 0; a_m[c] = 0;
        s_p[c] = 0; s_w[c] = 0; s_c[c] = 0; s_m[c] = 0;
        e_out[c] = 0; e_done[c] = 0;
      end
      return;
    end
    sel  = int'(cfg_chan);
    fire = cfg_valid && ((sel >= CH) || !m_pend[sel]);
    for (int c = 0; c < CH; c++) begin
      wr        = fire && (sel == c);
      e_done[c] = 0;
      peff      = (a_p[c] == 0) ? 1 : a_p[c];
      if (!m_run[c]) begin
        if (wr) begin
          a_p[c] = int'(cfg_period); a_w[c] = int'(cfg_width);
          a_c[c] = BURST_ON ? int'(cfg_count) : 0; a_m[c] = int'(cfg_mode);
        end else if (m_pend[c]) begin
          a_p[c] = s_p[c]; a_w[c] = s_w[c]; a_c[c] = s_c[c]; a_m[c] = s_m[c];
        end
        m_pend[c] = 0;
        if (ena && start[c] && !stop[c]) begin
          m_run[c] = 1; m_ph[c] = 0; m_np[c] = 0;
        end
      end else if (ena && stop[c]) begin
        m_run[c] = 0; m_ph[c] = 0;
        if (wr) begin
          s_p[c] = int'(cfg_period); s_w[c] = int'(cfg_width);
          s_c[c] = BURST_ON ? int'(cfg_count) : 0; s_m[c] = int'(cfg_mode);
          m_pend[c] = 1;
        end
      end else if (ena && (m_ph[c] + 1 == peff)) begin
        old_m = a_m[c];
        old_c = a_c[c];
        if (wr) begin
          a_p[c] = int'(cfg_period); a_w[c] = int'(cfg_width);
          a_c[c] = BURST_ON ? int'(cfg_count) : 0; a_m[c] = int'(cfg_mode);
        end else if (m_pend[c]) begin
          a_p[c] = s_p[c]; a_w[c] = s_w[c]; a_c[c] = s_c[c]; a_m[c] = s_m[c];
        end
        m_pend[c] = 0;
        m_ph[c]   = 0;
        if (old_m == 2 && BURST_ON) limit = (old_c == 0) ? 1 : old_c;
        else                        limit = 1;
        if (old_m != 0 && (m_np[c] + 1) >= limit) begin
          m_run[c]  = 0;
          e_done[c] = 1;
        end else begin
          m_np[c] = (m_np[c] + 1 > 255) ? 255 : m_np[c] + 1;
        end
      end else begin
        if (ena) m_ph[c] = m_ph[c] + 1;
        if (wr) begin
          s_p[c] = int'(cfg_period); s_w[c] = int'(cfg_width);
          s_c[c] = BURST_ON ? int'(cfg_count) : 0; s_m[c] = int'(cfg_mode);
          m_pend[c] = 1;
        end
      end
      e_out[c] = ena && m_run[c] && (m_ph[c] < a_w[c]);
    end
  endtask

  // One clock: check the handshake, predict the edge, queue the expectation, then pass the edge.
  task automatic tick();
    logic [2*CH-1:0] e;
    bit              exp_rdy;
    #1;
    if (!rst) begin
      exp_rdy = !((int'(cfg_chan) < CH) && m_pend[int'(cfg_chan)]);
      check("cfg_ready", 32'(cfg_ready), 32'(exp_rdy));
    end
    model_step();
    for (int c = 0; c < CH; c++) begin
      e[c]      = e_out[c];
      e[CH + c] = e_done[c];
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle_inputs();
    rst = 0; ena = 1; start = '0; stop = '0;
    cfg_valid = 0; cfg_chan = '0; cfg_period = '0; cfg_width = '0; cfg_count = '0; cfg_mode = '0;
  endtask

  task automatic write_cfg(input int ch, input int p, input int w, input int c, input int m);
    cfg_valid  = 1;
    cfg_chan   = CW'(ch);
    cfg_period = N'(p);
    cfg_width  = N'(w);
    cfg_count  = N'(c);
    cfg_mode   = 2'(m);
  endtask

  task automatic stop_all();
    idle_inputs(); stop = '1; tick(); idle_inputs();
  endtask

  // Monitor: every output cycle is compared against the oldest queued prediction.
  initial begin
    logic [2*CH-1:0] e;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("outputs", 32'({done, out}), 32'(e));
      end
    end
  end

  initial begin
    idle_inputs();
    rst = 1; start = '1; cfg_valid = 1; cfg_period = 8'd3; cfg_width = 8'd2;
    repeat (3) tick();
    check("reset_outputs", 32'({done, out}), 32'd0);
    idle_inputs();

    // Continuous, with config and start on the same edge.
    write_cfg(0, 5, 2, 0, 0); start[0] = 1; tick(); idle_inputs();
    check("cont_out0", 32'(out[0]), 32'd1);
    for (int i = 1; i < 10; i++) begin
      tick();
      check("cont_out0", 32'(out[0]), 32'((i % 5) < 2));
      check("cont_done0", 32'(done[0]), 32'd0);
    end

    // Live update mid-period; second write must be held off.
    tick(); tick();
    write_cfg(0, 2, 1, 0, 0); tick(); idle_inputs();
    write_cfg(0, 3, 3, 0, 0); #1;
    check("cfg_ready_busy", 32'(cfg_ready), 32'd0);
    tick(); idle_inputs();
    check("live_out0_p3", 32'(out[0]), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("live_out0", 32'(out[0]), 32'(i % 2));
    end
    stop_all();

    // Oneshot.
    write_cfg(1, 4, 1, 0, 1); tick(); idle_inputs();
    start[1] = 1; tick(); idle_inputs();
    check("oneshot_out1", 32'(out[1]), 32'd1);
    for (int i = 2; i <= 5; i++) begin
      tick();
      check("oneshot_out1", 32'(out[1]), 32'd0);
      check("oneshot_done1", 32'(done[1]), 32'(i == 5));
    end

    // Burst (single pulse when burst support is absent).
    write_cfg(2, 3, 1, 3, 2); tick(); idle_inputs();
    start[2] = 1; tick(); idle_inputs();
    check("burst_out2", 32'(out[2]), 32'd1);
    for (int i = 2; i <= 11; i++) begin
      tick();
      check("burst_out2", 32'(out[2]),
            32'(BURST_ON ? (i == 4 || i == 7) : 1'b0));
      check("burst_done2", 32'(done[2]), 32'(BURST_ON ? (i == 10) : (i == 4)));
    end
    stop_all();

    // Width extremes and zero period.
    write_cfg(1, 4, 0, 0, 0); tick(); idle_inputs();
    start[1] = 1; tick(); idle_inputs();
    write_cfg(2, 4, 7, 0, 0); tick(); idle_inputs();
    start[2] = 1; tick(); idle_inputs();
    for (int i = 0; i < 6; i++) begin
      tick();
      check("w0_out1", 32'(out[1]), 32'd0);
      check("wfull_out2", 32'(out[2]), 32'd1);
    end
    write_cfg(0, 0, 1, 0, 1); tick(); idle_inputs();
    start[0] = 1; tick(); idle_inputs();
    check("p0_out0", 32'(out[0]), 32'd1);
    tick();
    check("p0_done0", 32'({done[0], out[0]}), 32'd2);
    start[0] = 1; stop[0] = 1; tick(); idle_inputs();
    tick();
    check("stopstart_out0", 32'(out[0]), 32'd0);
    stop_all();

    // Enable freeze.
    write_cfg(0, 5, 3, 0, 0); tick(); idle_inputs();
    start[0] = 1; tick(); idle_inputs();
    tick();
    ena = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("ena_low_out", 32'({done, out}), 32'd0);
    end
    ena = 1;
    tick(); check("resume_out0", 32'(out[0]), 32'd1);
    tick(); check("resume_out0", 32'(out[0]), 32'd0);
    stop_all();

    // Reset during a burst.
    write_cfg(2, 3, 1, 3, 2); tick(); idle_inputs();
    start[2] = 1; tick(); idle_inputs();
    repeat (3) tick();
    rst = 1; tick(); idle_inputs();
    check("rst_burst_out", 32'({done, out}), 32'd0);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("rst_burst_done", 32'(done), 32'd0);
    end

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      rst        = ($urandom_range(0, 199) == 0);
      ena        = ($urandom_range(0, 9) != 0);
      for (int c = 0; c < CH; c++) begin
        start[c] = ($urandom_range(0, 5) == 0);
        stop[c]  = ($urandom_range(0, 19) == 0);
      end
      cfg_valid  = ($urandom_range(0, 3) == 0);
      cfg_chan   = CW'($urandom_range(0, 3));
      cfg_period = N'($urandom_range(0, 6));
      cfg_width  = N'($urandom_range(0, 7));
      cfg_count  = N'($urandom_range(0, 4));
      cfg_mode   = 2'($urandom_range(0, 3));
      tick();
    end

    idle_inputs();
    tick(); tick();
    #3;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
